// File: rtl/uart_rx_receiver_if.sv
// rtl/uart_rx_receiver_if.sv - line, clear and status bundle between the UART receiver and the core
// The core side (master) drives the serial pin and the clear pulse; the receiver (slave) reports data and flags.
interface uart_rx_receiver_if;
   logic       uart_rx;
   logic       rx_clear;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   modport master (
      output uart_rx,
      output rx_clear,
      input  rx_data,
      input  rx_valid,
      input  frame_error,
      input  overrun,
      input  busy
   );

   modport slave (
      input  uart_rx,
      input  rx_clear,
      output rx_data,
      output rx_valid,
      output frame_error,
      output overrun,
      output busy
   );
endinterface

// File: rtl/uart_rx_receiver.sv
// rtl/uart_rx_receiver.sv - 8N1 UART receiver with mid-bit sampling, held byte and sticky error flags
// The FSM leaves STOP at mid-stop-bit so a back-to-back start edge is never missed.
module uart_rx_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic                clk,
   input  logic                reset,
   uart_rx_receiver_if.slave   rx_if
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
   logic          rx_s;
   logic          stop_evt;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sync_q    <= 2'b11;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], rx_if.uart_rx};
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      stop_evt  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               shift_d[bit_idx_q] = rx_s;
               cnt_d              = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               stop_evt = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A clear in the same cycle as a good stop frees the holding register for the new byte.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (rx_if.rx_clear) begin
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end

      if (stop_evt) begin
         if (rx_s) begin
            if (!valid_q || rx_if.rx_clear) begin
               data_d  = shift_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   assign rx_if.rx_data     = data_q;
   assign rx_if.rx_valid    = valid_q;
   assign rx_if.frame_error = ferr_q;
   assign rx_if.overrun     = ovr_q;
   assign rx_if.busy        = (state_q != IDLE);

endmodule
